// File: rtl/uart_command_serializer.sv
// Streams a buffered command to the UART TX byte interface and appends the link terminator.
// Optional stall timeout is enabled by defining UART_CMD_SER_TIMEOUT_EN.
module uart_command_serializer #(
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1023:0] input_data,
  input  logic [7:0]    input_data_size,
  input  logic          start,
  input  logic          ble_side,
  input  logic          tx_ready,
  output logic [7:0]    output_byte,
  output logic          output_valid,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [7:0] MaxSize   = 8'd128;
  localparam logic [7:0] BleTerm   = 8'h0D;
  localparam logic [7:0] HostTerm1 = 8'hBE;
  localparam logic [7:0] HostTerm2 = 8'hEF;

  typedef enum logic [1:0] {StIdle, StSend, StTerm1, StTerm2} state_e;

  state_e          state_q, state_d;
  logic [1023:0]   data_q, data_d;
  logic [7:0]      size_q, size_d;
  logic            ble_q, ble_d;
  logic [6:0]      index_q, index_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            handshake;
  logic            last_byte;
  logic [6:0]      next_index;
  logic [7:0]      next_payload;
  logic [7:0]      term1_byte;

  assign handshake    = valid_q & tx_ready;
  assign last_byte    = ({1'b0, index_q} == (size_q - 8'd1));
  assign next_index   = index_q + 7'd1;
  assign next_payload = data_q[{next_index, 3'b000} +: 8];
  assign term1_byte   = ble_q ? BleTerm : HostTerm1;

`ifdef UART_CMD_SER_TIMEOUT_EN
  // Wide enough to hold TIMEOUT + 1, the first value that triggers the abort.
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (cnt_q > CntW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    size_d  = size_q;
    ble_d   = ble_q;
    index_d = index_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef UART_CMD_SER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (input_data_size > MaxSize) begin
            error_d = 1'b1;
          end else begin
            data_d  = input_data;
            size_d  = input_data_size;
            ble_d   = ble_side;
            index_d = '0;
            error_d = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            // Outputs are registered, so the first byte is loaded straight from the inputs.
            if (input_data_size != 8'd0) begin
              state_d = StSend;
              byte_d  = input_data[7:0];
            end else begin
              state_d = StTerm1;
              byte_d  = ble_side ? BleTerm : HostTerm1;
            end
          end
        end
      end
      StSend: begin
        if (handshake) begin
          if (last_byte) begin
            state_d = StTerm1;
            byte_d  = term1_byte;
          end else begin
            index_d = next_index;
            byte_d  = next_payload;
          end
        end
      end
      StTerm1: begin
        if (handshake) begin
          if (ble_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StTerm2;
            byte_d  = HostTerm2;
          end
        end
      end
      StTerm2: begin
        if (handshake) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef UART_CMD_SER_TIMEOUT_EN
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (handshake) begin
      cnt_d = '0;
    end else if (timeout_hit) begin
      state_d = StIdle;
      error_d = 1'b1;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      cnt_d   = '0;
    end else if (valid_q) begin
      cnt_d = cnt_q + CntW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      error_q <= 1'b0;
`ifdef UART_CMD_SER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef UART_CMD_SER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // The command latch only matters once a start is accepted, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    size_q <= size_d;
    ble_q  <= ble_d;
  end

  assign output_byte  = byte_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_uart_command_serializer.sv
// Scoreboard bench for uart_command_serializer: expected bytes are queued at stimulus time
// and a negedge monitor pops and compares on every handshake.
module tb_uart_command_serializer;

  logic          clk = 1'b0;
  logic          reset;
  logic [1023:0] input_data;
  logic [7:0]    input_data_size;
  logic          start;
  logic          ble_side;
  logic          tx_ready;
  logic [7:0]    output_byte;
  logic          output_valid;
  logic          busy;
  logic          done;
  logic          error;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_command_serializer #(
    .TIMEOUT(10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .input_data_size(input_data_size),
    .start          (start),
    .ble_side       (ble_side),
    .tx_ready       (tx_ready),
    .output_byte    (output_byte),
    .output_valid   (output_valid),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] size, input logic ble, input logic [1023:0] data);
    input_data      = data;
    input_data_size = size;
    ble_side        = ble;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] size, input logic ble, input logic [1023:0] data);
    for (int k = 0; k < int'(size); k++) exp_q.push_back(data[8*k +: 8]);
    if (ble) begin
      exp_q.push_back(8'h0D);
    end else begin
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hEF);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, output_valid}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && output_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_extra: got 0x%0h, want no byte", output_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        check("stream_byte", {24'd0, output_byte}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1023:0] d;
    logic          pat[5];
    int            n;

    reset           = 1'b1;
    start           = 1'b0;
    ble_side        = 1'b0;
    tx_ready        = 1'b1;
    input_data      = '0;
    input_data_size = 8'd0;
    tick();
    tick();
    check("rst_byte", {24'd0, output_byte}, 32'h00);
    check("rst_valid", {31'd0, output_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd1);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Host frame 41 42 43 -> five back-to-back handshakes.
    d = '0;
    d[23:0] = 24'h434241;
    push_frame(8'd3, 1'b0, d);
    issue(8'd3, 1'b0, d);
    check("host_valid_rise", {31'd0, output_valid}, 32'd1);
    check("host_busy", {31'd0, busy}, 32'd1);
    check("host_done_low", {31'd0, done}, 32'd0);
    repeat (5) tick();
    check_idle("host_end");
    check("host_error", {31'd0, error}, 32'd0);

    // BLE frame with backpressure pattern 1,0,0,1,1.
    d = '0;
    d[15:0] = 16'h2010;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    push_frame(8'd2, 1'b1, d);
    issue(8'd2, 1'b1, d);
    for (int i = 0; i < 5; i++) begin
      tx_ready = pat[i];
      if (!pat[i]) begin
        check("stall_hold_byte", {24'd0, output_byte}, 32'h20);
        check("stall_hold_valid", {31'd0, output_valid}, 32'd1);
      end
      tick();
    end
    tx_ready = 1'b1;
    check_idle("ble_end");

    // Empty host frame: terminator only.
    push_frame(8'd0, 1'b0, '0);
    issue(8'd0, 1'b0, '0);
    check("empty_valid", {31'd0, output_valid}, 32'd1);
    repeat (2) tick();
    check_idle("empty_end");

    // Full 128-byte frame, BLE terminator.
    for (int k = 0; k < 128; k++) d[8*k +: 8] = 8'(k) ^ 8'h5A;
    push_frame(8'd128, 1'b1, d);
    issue(8'd128, 1'b1, d);
    repeat (127) tick();
    check("full_last_byte", {24'd0, output_byte}, 32'h25);
    repeat (2) tick();
    check_idle("full_end");

    // Oversize request is rejected without output.
    issue(8'd129, 1'b0, d);
    check("over_error", {31'd0, error}, 32'd1);
    tick();
    check_idle("over_idle");

    // Next valid start clears the sticky error.
    d = '0;
    d[7:0] = 8'h77;
    push_frame(8'd1, 1'b0, d);
    issue(8'd1, 1'b0, d);
    check("clear_error", {31'd0, error}, 32'd0);
    repeat (3) tick();
    check_idle("clear_end");

    // Reset after two bytes of a ten-byte frame.
    for (int k = 0; k < 10; k++) d[8*k +: 8] = 8'hC0 + 8'(k);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    issue(8'd10, 1'b0, d);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_byte", {24'd0, output_byte}, 32'h00);
    check("midrst_error", {31'd0, error}, 32'd0);
    check_idle("midrst");
    d = '0;
    d[7:0] = 8'h99;
    push_frame(8'd1, 1'b0, d);
    issue(8'd1, 1'b0, d);
    repeat (3) tick();
    check_idle("postrst_end");

    // Start pulsed mid-frame with a different buffer must be ignored.
    d = '0;
    d[31:0] = 32'hA4A3A2A1;
    push_frame(8'd4, 1'b0, d);
    issue(8'd4, 1'b0, d);
    tick();
    d = '0;
    d[15:0] = 16'hFFFF;
    issue(8'd2, 1'b1, d);
    repeat (4) tick();
    check_idle("busy_start_end");
    tick();
    check("busy_start_no_new", {31'd0, output_valid}, 32'd0);

`ifdef UART_CMD_SER_TIMEOUT_EN
    // Stall until the wait counter passes TIMEOUT=10.
    tx_ready = 1'b0;
    d = '0;
    d[7:0] = 8'h55;
    issue(8'd1, 1'b0, d);
    n = 0;
    while (output_valid && n < 100) begin
      n++;
      tick();
    end
    check("timeout_valid_cycles", n, 32'd12);
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_done", {31'd0, done}, 32'd1);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    tx_ready = 1'b1;
    push_frame(8'd0, 1'b1, '0);
    issue(8'd0, 1'b1, '0);
    check("timeout_clear", {31'd0, error}, 32'd0);
    tick();
    check_idle("timeout_recover");
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
